// File: rtl/decode_execute_stage.sv
// Decode (D) and execute (E) pipeline slice of the MIPS core: splits the
// fetched instruction into fields/control, then registers the ALU result.
module decode_execute_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr_in,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [31:0] alu_result,
  output logic        alu_zero,
  output logic [4:0]  dest_addr,
  output logic        write_en,
  output logic        mem_op,
  output logic        branch_op,
  output logic        nop,
  output logic        mem_store,
  output logic [5:0]  op_type,
  output logic [25:0] branch_imm,
  output logic [31:0] instr_out
);

  typedef enum logic [3:0] {
    ALU_ZERO, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_t;

  typedef enum logic [1:0] {
    RHS_RS  = 2'b00,
    RHS_RT  = 2'b01,
    RHS_SH  = 2'b10,
    RHS_IMM = 2'b11
  } rhs_sel_t;

  // Decode of instr_in (combinational)
  alu_op_t  dec_alu_op;
  rhs_sel_t dec_rhs_sel;
  logic     dec_lhs_rt, dec_zext, dec_we, dec_mem, dec_store, dec_br, dec_nop;
  logic [4:0] dec_dest;

  // D-stage registers
  logic [31:0] instr_d;
  alu_op_t     alu_op_d;
  rhs_sel_t    rhs_sel_d;
  logic        lhs_rt_d, zext_d, we_d, mem_d, store_d, br_d, nop_d;
  logic [4:0]  dest_d;

  // Execute datapath
  logic [31:0] lhs, rhs, imm_ext, result;

  wire [5:0] op   = instr_in[31:26];
  wire [5:0] func = instr_in[5:0];
  wire [4:0] rt_f = instr_in[20:16];
  wire [4:0] rd_f = instr_in[15:11];

  always_comb begin
    dec_alu_op  = ALU_ZERO;
    dec_rhs_sel = RHS_RT;
    dec_lhs_rt  = 1'b0;
    dec_zext    = 1'b0;
    dec_we      = 1'b0;
    dec_mem     = 1'b0;
    dec_store   = 1'b0;
    dec_br      = 1'b0;
    dec_nop     = 1'b1;
    dec_dest    = '0;
    if (instr_in != '0) begin
      case (op)
        6'h00: begin
          dec_nop  = 1'b0;
          dec_we   = 1'b1;
          dec_dest = rd_f;
          case (func)
            6'h00: begin dec_alu_op = ALU_SLL;  dec_lhs_rt = 1'b1; dec_rhs_sel = RHS_SH; end
            6'h02: begin dec_alu_op = ALU_SRL;  dec_lhs_rt = 1'b1; dec_rhs_sel = RHS_SH; end
            6'h03: begin dec_alu_op = ALU_SRA;  dec_lhs_rt = 1'b1; dec_rhs_sel = RHS_SH; end
            6'h04: begin dec_alu_op = ALU_SLL;  dec_lhs_rt = 1'b1; dec_rhs_sel = RHS_RS; end
            6'h06: begin dec_alu_op = ALU_SRL;  dec_lhs_rt = 1'b1; dec_rhs_sel = RHS_RS; end
            6'h07: begin dec_alu_op = ALU_SRA;  dec_lhs_rt = 1'b1; dec_rhs_sel = RHS_RS; end
            6'h20, 6'h21: dec_alu_op = ALU_ADD;
            6'h22, 6'h23: dec_alu_op = ALU_SUB;
            6'h24: dec_alu_op = ALU_AND;
            6'h25: dec_alu_op = ALU_OR;
            6'h26: dec_alu_op = ALU_XOR;
            6'h27: dec_alu_op = ALU_NOR;
            6'h2A: dec_alu_op = ALU_SLT;
            6'h2B: dec_alu_op = ALU_SLTU;
            default: begin dec_nop = 1'b1; dec_we = 1'b0; dec_dest = '0; end
          endcase
        end
        6'h02, 6'h03: begin
          dec_nop = 1'b0;
          dec_br  = 1'b1;
        end
        6'h04, 6'h05: begin
          dec_nop    = 1'b0;
          dec_br     = 1'b1;
          dec_alu_op = ALU_SUB;
        end
        6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
          dec_nop     = 1'b0;
          dec_we      = 1'b1;
          dec_dest    = rt_f;
          dec_rhs_sel = RHS_IMM;
          dec_zext    = (op >= 6'h0C);
          case (op[2:0])
            3'h0, 3'h1: dec_alu_op = ALU_ADD;
            3'h2:       dec_alu_op = ALU_SLT;
            3'h3:       dec_alu_op = ALU_SLTU;
            3'h4:       dec_alu_op = ALU_AND;
            3'h5:       dec_alu_op = ALU_OR;
            3'h6:       dec_alu_op = ALU_XOR;
            default:    dec_alu_op = ALU_LUI;
          endcase
        end
        6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
          dec_nop     = 1'b0;
          dec_mem     = 1'b1;
          dec_we      = 1'b1;
          dec_dest    = rt_f;
          dec_rhs_sel = RHS_IMM;
          dec_alu_op  = ALU_ADD;
        end
        6'h28, 6'h29, 6'h2B: begin
          dec_nop     = 1'b0;
          dec_mem     = 1'b1;
          dec_store   = 1'b1;
          dec_dest    = rt_f;
          dec_rhs_sel = RHS_IMM;
          dec_alu_op  = ALU_ADD;
        end
        default: ;
      endcase
    end
    // Writes to $0 are dropped here so both stages agree on write_en
    if (dec_dest == '0)
      dec_we = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr_d   <= '0;
      alu_op_d  <= ALU_ZERO;
      rhs_sel_d <= RHS_RT;
      lhs_rt_d  <= 1'b0;
      zext_d    <= 1'b0;
      we_d      <= 1'b0;
      mem_d     <= 1'b0;
      store_d   <= 1'b0;
      br_d      <= 1'b0;
      nop_d     <= 1'b1;
      dest_d    <= '0;
    end else begin
      instr_d   <= instr_in;
      alu_op_d  <= dec_alu_op;
      rhs_sel_d <= dec_rhs_sel;
      lhs_rt_d  <= dec_lhs_rt;
      zext_d    <= dec_zext;
      we_d      <= dec_we;
      mem_d     <= dec_mem;
      store_d   <= dec_store;
      br_d      <= dec_br;
      nop_d     <= dec_nop;
      dest_d    <= dec_dest;
    end
  end

  assign rs_addr = instr_d[25:21];
  assign rt_addr = instr_d[20:16];

  always_comb begin
    imm_ext = zext_d ? {16'h0000, instr_d[15:0]} : {{16{instr_d[15]}}, instr_d[15:0]};
    lhs     = lhs_rt_d ? rt_val : rs_val;
    case (rhs_sel_d)
      RHS_RS:  rhs = rs_val;
      RHS_RT:  rhs = rt_val;
      RHS_SH:  rhs = {27'b0, instr_d[10:6]};
      default: rhs = imm_ext;
    endcase
    case (alu_op_d)
      ALU_ADD:  result = lhs + rhs;
      ALU_SUB:  result = lhs - rhs;
      ALU_AND:  result = lhs & rhs;
      ALU_OR:   result = lhs | rhs;
      ALU_XOR:  result = lhs ^ rhs;
      ALU_NOR:  result = ~(lhs | rhs);
      ALU_SLT:  result = {31'b0, $signed(lhs) < $signed(rhs)};
      ALU_SLTU: result = {31'b0, lhs < rhs};
      ALU_SLL:  result = lhs << rhs[4:0];
      ALU_SRL:  result = lhs >> rhs[4:0];
      ALU_SRA:  result = $unsigned($signed(lhs) >>> rhs[4:0]);
      ALU_LUI:  result = {rhs[15:0], 16'h0000};
      default:  result = '0;
    endcase
  end

  // alu_zero is suppressed for bubbles so reset and a decoded 0x0 look identical
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alu_result <= '0;
      alu_zero   <= 1'b0;
      dest_addr  <= '0;
      write_en   <= 1'b0;
      mem_op     <= 1'b0;
      branch_op  <= 1'b0;
      nop        <= 1'b1;
      mem_store  <= 1'b0;
      op_type    <= '0;
      branch_imm <= '0;
      instr_out  <= '0;
    end else begin
      alu_result <= result;
      alu_zero   <= (result == '0) && !nop_d;
      dest_addr  <= dest_d;
      write_en   <= we_d;
      mem_op     <= mem_d;
      branch_op  <= br_d;
      nop        <= nop_d;
      mem_store  <= store_d;
      op_type    <= instr_d[31:26];
      branch_imm <= instr_d[25:0];
      instr_out  <= instr_d;
    end
  end

endmodule

// File: tb/tb_decode_execute_stage.sv
// Directed bench for decode_execute_stage with hand-computed expectations.
module tb_decode_execute_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instr_in, rs_val, rt_val;
  logic [4:0]  rs_addr, rt_addr, dest_addr;
  logic [31:0] alu_result, instr_out;
  logic        alu_zero, write_en, mem_op, branch_op, nop, mem_store;
  logic [5:0]  op_type;
  logic [25:0] branch_imm;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  decode_execute_stage dut (
    .clock(clock), .reset(reset), .instr_in(instr_in),
    .rs_val(rs_val), .rt_val(rt_val),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .dest_addr(dest_addr), .write_en(write_en),
    .mem_op(mem_op), .branch_op(branch_op), .nop(nop),
    .mem_store(mem_store), .op_type(op_type),
    .branch_imm(branch_imm), .instr_out(instr_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one instruction; operands are driven while it sits in D.
  task automatic run_one(input logic [31:0] ins, input logic [31:0] rsv, input logic [31:0] rtv);
    instr_in = ins;
    tick();
    rs_val   = rsv;
    rt_val   = rtv;
    instr_in = '0;
    tick();
  endtask

  initial begin
    reset    = 1'b1;
    instr_in = '0;
    rs_val   = '0;
    rt_val   = '0;
    #12;
    check("rst_result", alu_result, 32'h0);
    check("rst_nop",    {31'b0, nop}, 32'h1);
    check("rst_zero",   {31'b0, alu_zero}, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // ADD $3,$1,$2
    instr_in = 32'h00221820;
    tick();
    check("add_rs_addr", {27'b0, rs_addr}, 32'd1);
    check("add_rt_addr", {27'b0, rt_addr}, 32'd2);
    rs_val = 32'd5; rt_val = 32'd7; instr_in = '0;
    tick();
    check("add_result", alu_result, 32'd12);
    check("add_dest",   {27'b0, dest_addr}, 32'd3);
    check("add_we",     {31'b0, write_en}, 32'd1);
    check("add_nop",    {31'b0, nop}, 32'd0);
    check("add_instr",  instr_out, 32'h00221820);

    // Mid-stream asynchronous reset
    instr_in = 32'h2422FFFF;
    tick();
    rs_val = 32'h10;
    #2 reset = 1'b1;
    #1;
    check("mrst_result", alu_result, 32'h0);
    check("mrst_nop",    {31'b0, nop}, 32'h1);
    check("mrst_rsaddr", {27'b0, rs_addr}, 32'h0);
    check("mrst_dest",   {27'b0, dest_addr}, 32'h0);
    check("mrst_we",     {31'b0, write_en}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    run_one(32'h00000000, 32'h0, 32'h0);
    check("zero_nop", {31'b0, nop}, 32'h1);
    check("zero_we",  {31'b0, write_en}, 32'h0);

    run_one(32'h2422FFFF, 32'h10, 32'h0);
    check("addiu_result", alu_result, 32'h0000000F);
    check("addiu_dest",   {27'b0, dest_addr}, 32'd2);
    run_one(32'h3422FFFF, 32'h0, 32'h0);
    check("ori_result", alu_result, 32'h0000FFFF);
    run_one(32'h3C021234, 32'h0, 32'h0);
    check("lui_result", alu_result, 32'h12340000);

    run_one(32'h00052103, 32'h0, 32'h80000000);
    check("sra_result", alu_result, 32'hF8000000);
    check("sra_dest",   {27'b0, dest_addr}, 32'd4);

    run_one(32'h0022182A, 32'hFFFFFFFF, 32'h1);
    check("slt_result", alu_result, 32'h1);
    run_one(32'h0022182B, 32'hFFFFFFFF, 32'h1);
    check("sltu_result", alu_result, 32'h0);

    // ADD with rd=$0 must not request a write
    run_one(32'h00220020, 32'd1, 32'd2);
    check("r0_result", alu_result, 32'd3);
    check("r0_we",     {31'b0, write_en}, 32'd0);

    // Unsupported opcode becomes a bubble
    run_one(32'hFC000000, 32'h55, 32'h66);
    check("bad_nop",    {31'b0, nop}, 32'd1);
    check("bad_result", alu_result, 32'd0);

    // BEQ with equal operands
    run_one(32'h10220003, 32'h42, 32'h42);
    check("beq_br",   {31'b0, branch_op}, 32'd1);
    check("beq_zero", {31'b0, alu_zero}, 32'd1);
    check("beq_we",   {31'b0, write_en}, 32'd0);
    check("beq_imm",  {6'b0, branch_imm}, 32'h00220003);

    // Back-to-back LW then SW
    instr_in = 32'h8C220008;
    tick();
    rs_val = 32'h100; rt_val = 32'h0;
    instr_in = 32'hAC220008;
    tick();
    check("lw_result", alu_result, 32'h108);
    check("lw_mem",    {31'b0, mem_op}, 32'd1);
    check("lw_we",     {31'b0, write_en}, 32'd1);
    check("lw_dest",   {27'b0, dest_addr}, 32'd2);
    check("lw_store",  {31'b0, mem_store}, 32'd0);
    rs_val = 32'h100;
    instr_in = '0;
    tick();
    check("sw_result", alu_result, 32'h108);
    check("sw_store",  {31'b0, mem_store}, 32'd1);
    check("sw_we",     {31'b0, write_en}, 32'd0);
    check("sw_op",     {26'b0, op_type}, 32'h2B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
